softbit_packer: RTL and testbench

- Upstream stage of viterbi_core: accepts a serial stream of 8-bit soft bits from the demapper and packs 1–3 soft bits per trellis step into one 24-bit word.
- Writes packed words into the source SRAM that viterbi_core later reads via src_addr_o/src_rdata_i.
- Once a full frame is stored and the core is idle, issues the single-cycle frame_start pulse to viterbi_core.

---
 rtl/softbit_packer_pkg.sv | 22 ++
 rtl/softbit_packer_lane_assembler.sv | 78 +++++++
 rtl/softbit_packer.sv | 133 +++++++++++++
 tb/tb_softbit_packer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softbit_packer_pkg.sv
// Shared constants, FSM state type and helpers for the soft-bit packer
// that feeds the viterbi_core source SRAM.
package viterbi_pkg;

  localparam int SB_W       = 8;
  localparam int SRC_ADDR_W = 12;
  localparam int LEN_W      = 12;
  localparam int WORD_W     = 3 * SB_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_CORE,
    START
  } state_t;

  // A code_n of 0 is a legacy encoding for rate 1/3
  function automatic logic [1:0] effective_n(input logic [1:0] code_n);
    return (code_n == 2'd0) ? 2'd3 : code_n;
  endfunction

endpackage

// File: rtl/softbit_packer_lane_assembler.sv
// Collects soft bits into the lanes of one packed word and hands the
// finished word out one cycle after its completing soft bit arrives.
// Lanes at or above the active lane count are always written as zero.
module lane_assembler #(
  parameter int SB_W = viterbi_pkg::SB_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [SB_W-1:0]   data_i,
  input  logic [1:0]        n_i,
  input  logic              last_i,
  output logic              lane_full_o,
  output logic              done_o,
  output logic              word_valid_o,
  output logic [3*SB_W-1:0] word_o
);

  logic [1:0]        lane_q, lane_d;
  logic [3*SB_W-1:0] acc_q, acc_d;
  logic [3*SB_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [3*SB_W-1:0] merged;

  // A word finishes on the last active lane, or early when the frame ends
  assign lane_full_o  = (lane_q == (n_i - 2'd1));
  assign done_o       = accept_i && (lane_full_o || last_i);
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  // Insert the incoming soft bit into the current lane, zeroing unused lanes
  always_comb begin
    merged = acc_q;
    for (int i = 0; i < 3; i++) begin
      if (lane_q == 2'(i)) merged[i*SB_W +: SB_W] = data_i;
      if (2'(i) >= n_i)    merged[i*SB_W +: SB_W] = '0;
    end
  end

  // Lane advance, word hand-off and accumulator recycling
  always_comb begin
    lane_d  = lane_q;
    acc_d   = acc_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (accept_i) begin
      if (done_o) begin
        valid_d = 1'b1;
        word_d  = merged;
        acc_d   = '0;
        lane_d  = '0;
      end else begin
        acc_d  = merged;
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // Register file of the assembler; reset drops any pending word
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/softbit_packer.sv
// Packs a serial soft-bit stream into 24-bit trellis-step words, writes
// them to the viterbi_core source SRAM and kicks off the core once the
// whole frame is stored and the core has gone idle.
module softbit_packer
  import viterbi_pkg::*;
#(
  parameter int SRC_ADDR_W = viterbi_pkg::SRC_ADDR_W,
  parameter int SB_W       = viterbi_pkg::SB_W,
  parameter int LEN_W      = viterbi_pkg::LEN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [1:0]            code_n_i,
  input  logic [LEN_W-1:0]      step_count_i,
  input  logic [SRC_ADDR_W-1:0] src_start_addr_i,
  input  logic                  sb_valid_i,
  input  logic [SB_W-1:0]       sb_data_i,
  input  logic                  sb_last_i,
  output logic                  sb_ready_o,
  output logic                  src_wr_o,
  output logic [SRC_ADDR_W-1:0] src_waddr_o,
  output logic [3*SB_W-1:0]     src_wdata_o,
  input  logic                  core_busy_i,
  output logic                  frame_start_o,
  output logic                  busy_o,
  output logic                  len_err_o
);

  state_t                state_q, state_d;
  logic [1:0]            n_q, n_d;
  logic [LEN_W-1:0]      step_q, step_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [SRC_ADDR_W-1:0] addr_q, addr_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  clear;
  logic                  lane_full;
  logic                  done;
  logic                  word_valid;
  logic [3*SB_W-1:0]     word;
  logic                  final_word;
  logic                  final_bit;

  assign accept     = (state_q == FILL) && sb_valid_i;
  assign clear      = (state_q == IDLE) && cfg_start_i;
  assign final_word = (cnt_q == (step_q - LEN_W'(1)));
  assign final_bit  = lane_full && final_word;

  lane_assembler #(
    .SB_W(SB_W)
  ) u_lanes (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .accept_i    (accept),
    .data_i      (sb_data_i),
    .n_i         (n_q),
    .last_i      (sb_last_i),
    .lane_full_o (lane_full),
    .done_o      (done),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  assign sb_ready_o    = (state_q == FILL);
  assign src_wr_o      = word_valid;
  assign src_waddr_o   = addr_q;
  assign src_wdata_o   = word;
  assign frame_start_o = (state_q == START);
  assign busy_o        = (state_q != IDLE);
  assign len_err_o     = err_q;

  // Frame FSM with address/word counters; a length error is flagged when
  // sb_last_i disagrees with the configured frame length
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    if (word_valid) addr_d = addr_q + SRC_ADDR_W'(1);
    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          n_d     = effective_n(code_n_i);
          step_d  = step_count_i;
          addr_d  = src_start_addr_i;
          cnt_d   = '0;
          state_d = (step_count_i == '0) ? WAIT_CORE : FILL;
        end
      end
      FILL: begin
        if (done) begin
          if (lane_full) cnt_d = cnt_q + LEN_W'(1);
          err_d = final_bit ? !sb_last_i : sb_last_i;
          if (final_bit || sb_last_i) state_d = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (!core_busy_i) state_d = START;
      end
      START: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts the frame without any hand-off
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      n_q     <= 2'd3;
      step_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_softbit_packer.sv
// Scoreboard bench for softbit_packer: each scenario pushes the SRAM
// writes it expects, and a negedge monitor pops and compares them.
module tb_softbit_packer;

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [1:0]  code_n = 2'd0;
  logic [11:0] step_count = '0;
  logic [11:0] start_addr = '0;
  logic        sb_valid = 1'b0;
  logic [7:0]  sb_data = '0;
  logic        sb_last = 1'b0;
  logic        core_busy = 1'b0;
  logic        sb_ready, src_wr, frame_start, busy, len_err;
  logic [11:0] src_waddr;
  logic [23:0] src_wdata;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   wr_count = 0;
  int   fs_count = 0;
  exp_t exp_q[$];
  logic [7:0] sb_mem [0:15];

  softbit_packer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_start_i     (cfg_start),
    .code_n_i        (code_n),
    .step_count_i    (step_count),
    .src_start_addr_i(start_addr),
    .sb_valid_i      (sb_valid),
    .sb_data_i       (sb_data),
    .sb_last_i       (sb_last),
    .sb_ready_o      (sb_ready),
    .src_wr_o        (src_wr),
    .src_waddr_o     (src_waddr),
    .src_wdata_o     (src_wdata),
    .core_busy_i     (core_busy),
    .frame_start_o   (frame_start),
    .busy_o          (busy),
    .len_err_o       (len_err)
  );

  always #5 clk = ~clk;

  // Monitor: every SRAM write is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) fs_count++;
      if (len_err && !src_wr) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL len_err_alone: len_err_o=1 without a write");
      end
      if (src_wr) begin
        wr_count++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_write: addr=%h data=%h err=%b, none expected",
                   src_waddr, src_wdata, len_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({src_waddr, src_wdata, len_err} !== {e.addr, e.data, e.err}) begin
            tests_failed++;
            $display("[TB] FAIL write: got addr=%h data=%h err=%b, expected addr=%h data=%h err=%b",
                     src_waddr, src_wdata, len_err, e.addr, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic push(input logic [11:0] a, input logic [23:0] d, input logic e);
    exp_t x;
    x.addr = a; x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic start_frame(input logic [1:0] n, input logic [11:0] steps, input logic [11:0] addr);
    code_n = n; step_count = steps; start_addr = addr; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic drive_bits(input int count, input bit bubbles, input int last_at);
    for (int i = 0; i < count; i++) begin
      int guard;
      guard = 0;
      sb_valid = 1'b1; sb_data = sb_mem[i]; sb_last = (i == last_at);
      while (!sb_ready && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      if (guard >= 50) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL ready_timeout: sb_ready_o=0 at bit %0d, expected 1", i);
        sb_valid = 1'b0; sb_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
      sb_valid = 1'b0; sb_last = 1'b0;
      if (bubbles) begin @(posedge clk); #1; end
    end
  endtask

  // Waits for one frame_start pulse, then checks the scoreboard drained
  task automatic finish_frame(input string name, input int writes_expected, input int wr_before);
    int fs_before;
    int guard;
    fs_before = fs_count;
    guard = 0;
    while (fs_count == fs_before && guard < 300) begin
      @(posedge clk); #1; guard++;
    end
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if (fs_count != fs_before + 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_frame_start: saw %0d pulses, expected 1", name, fs_count - fs_before);
    end
    tests_run++;
    if (wr_count - wr_before != writes_expected || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_writes: saw %0d writes (%0d pending), expected %0d",
               name, wr_count - wr_before, exp_q.size(), writes_expected);
      exp_q.delete();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle: busy_o=%b, expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({sb_ready, src_wr, src_waddr, src_wdata, frame_start, busy, len_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ready=%b wr=%b addr=%h data=%h fs=%b busy=%b err=%b, expected all 0",
               sb_ready, src_wr, src_waddr, src_wdata, frame_start, busy, len_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rate3();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 12; i++) sb_mem[i] = 8'(i + 1);
    push(12'h000, 24'h030201, 1'b0);
    push(12'h001, 24'h060504, 1'b0);
    push(12'h002, 24'h090807, 1'b0);
    push(12'h003, 24'h0C0B0A, 1'b0);
    start_frame(2'd3, 12'd4, 12'h000);
    tests_run++;
    if (busy !== 1'b1 || sb_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rate3_fill: busy=%b ready=%b, expected 1 1", busy, sb_ready);
    end
    drive_bits(12, 1'b0, 11);
    finish_frame("rate3", 4, w0);
  endtask

  task automatic test_rate2_bubbles();
    int w0;
    w0 = wr_count;
    sb_mem[0] = 8'hF7; sb_mem[1] = 8'hF1; sb_mem[2] = 8'hFF; sb_mem[3] = 8'h80;
    push(12'h000, 24'h00F1F7, 1'b0);
    push(12'h001, 24'h0080FF, 1'b0);
    start_frame(2'd2, 12'd2, 12'h000);
    drive_bits(4, 1'b1, 3);
    finish_frame("rate2", 2, w0);
  endtask

  task automatic test_wrap();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 4; i++) sb_mem[i] = 8'hA0 + 8'(i);
    push(12'hFFE, 24'h0000A0, 1'b0);
    push(12'hFFF, 24'h0000A1, 1'b0);
    push(12'h000, 24'h0000A2, 1'b0);
    push(12'h001, 24'h0000A3, 1'b0);
    start_frame(2'd1, 12'd4, 12'hFFE);
    drive_bits(4, 1'b0, 3);
    finish_frame("wrap", 4, w0);
  endtask

  task automatic test_early_last();
    int w0;
    w0 = wr_count;
    for (int i = 0; i < 5; i++) sb_mem[i] = 8'h11 + 8'(i);
    push(12'h040, 24'h131211, 1'b0);
    push(12'h041, 24'h001514, 1'b1);
    start_frame(2'd3, 12'd8, 12'h040);
    drive_bits(5, 1'b0, 4);
    tests_run++;
    if (sb_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL early_ready: sb_ready_o=%b after early last, expected 0", sb_ready);
    end
    finish_frame("early", 2, w0);
  endtask

  task automatic test_missing_last_and_code0();
    int w0;
    w0 = wr_count;
    sb_mem[0] = 8'h81; sb_mem[1] = 8'h7E; sb_mem[2] = 8'h33;
    push(12'h200, 24'h337E81, 1'b1);
    start_frame(2'd0, 12'd1, 12'h200);
    drive_bits(3, 1'b0, -1);
    finish_frame("nolast", 1, w0);
  endtask

  task automatic test_zero_steps();
    int w0;
    w0 = wr_count;
    start_frame(2'd2, 12'd0, 12'h300);
    finish_frame("zero", 0, w0);
  endtask

  task automatic test_handoff();
    int w0;
    bit bad;
    w0 = wr_count;
    bad = 1'b0;
    sb_mem[0] = 8'h5A; sb_mem[1] = 8'hA5;
    push(12'h100, 24'h00005A, 1'b0);
    push(12'h101, 24'h0000A5, 1'b0);
    core_busy = 1'b1;
    start_frame(2'd1, 12'd2, 12'h100);
    drive_bits(2, 1'b0, 1);
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b1 || frame_start !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("[TB] FAIL handoff_hold: busy_o/frame_start_o wrong while core busy, expected 1/0");
    end
    @(posedge clk); #1;
    core_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (frame_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL handoff_early: frame_start_o=%b in busy-fall cycle, expected 0", frame_start);
    end
    @(negedge clk);
    tests_run++;
    if (frame_start !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL handoff_pulse: frame_start_o=%b busy_o=%b, expected 1 1", frame_start, busy);
    end
    @(negedge clk);
    tests_run++;
    if (frame_start !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL handoff_end: frame_start_o=%b busy_o=%b, expected 0 0", frame_start, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wr_count - w0 != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL handoff_writes: saw %0d writes, expected 2", wr_count - w0);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_fill();
    int w0;
    int f0;
    w0 = wr_count;
    f0 = fs_count;
    sb_mem[0] = 8'h21; sb_mem[1] = 8'h22;
    start_frame(2'd3, 12'd2, 12'h050);
    drive_bits(2, 1'b0, -1);
    rst = 1'b1;
    #2;
    tests_run++;
    if ({sb_ready, src_wr, src_waddr, src_wdata, frame_start, busy, len_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got ready=%b wr=%b addr=%h data=%h fs=%b busy=%b err=%b, expected all 0",
               sb_ready, src_wr, src_waddr, src_wdata, frame_start, busy, len_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    tests_run++;
    if (wr_count != w0 || fs_count != f0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_quiet: %0d writes %0d starts after reset, expected 0 0",
               wr_count - w0, fs_count - f0);
    end
    sb_mem[0] = 8'h31; sb_mem[1] = 8'h32; sb_mem[2] = 8'h33;
    push(12'h060, 24'h333231, 1'b0);
    start_frame(2'd3, 12'd1, 12'h060);
    drive_bits(3, 1'b0, 2);
    finish_frame("after_reset", 1, w0);
  endtask

  initial begin
    test_reset();
    test_rate3();
    test_rate2_bubbles();
    test_wrap();
    test_early_last();
    test_missing_last_and_code0();
    test_zero_steps();
    test_handoff();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
